// File: rtl/debug_link_rx.sv
// debug_link_rx: captures words announced by toggles of an asynchronous link_clk into a show-ahead FIFO.
// Define DEBUG_LINK_RX_OVFCNT_EN to build ovf_cnt as a saturating lost-word counter (otherwise tied to 0).
module debug_link_rx #(
    parameter int WIDTH  = 13,
    parameter int DEPTH  = 16,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   link_clk,
    input  logic [WIDTH-1:0]       link_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   ovf_clr,
    output logic [7:0]             ovf_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE} state_t;

    state_t           state;
    logic [7:0]       settle_cnt;
    logic             sync1, sync2, hist;
    logic [1:0]       mask_cnt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             toggle, full, word_nz, do_push, do_pop;
    logic             drop_full, rate_viol, set_ovf;

    // The mask keeps a link_clk that is already high at reset release from looking like a word.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            hist     <= 1'b0;
            mask_cnt <= 2'd3;
        end else begin
            sync1 <= link_clk;
            sync2 <= sync1;
            hist  <= sync2;
            if (mask_cnt != 2'd0)
                mask_cnt <= mask_cnt - 2'd1;
        end
    end

    assign toggle = (sync2 ^ hist) && (mask_cnt == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (toggle) begin
                        settle_cnt <= 8'(SETTLE);
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (settle_cnt == 8'd0)
                        state <= SAMPLE;
                    else
                        settle_cnt <= settle_cnt - 8'd1;
                end
                SAMPLE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign full      = (level == FULL_LEVEL);
    assign word_nz   = (link_data != '0);
    assign do_push   = (state == SAMPLE) && word_nz && !full;
    assign drop_full = (state == SAMPLE) && word_nz && full;
    assign rate_viol = toggle && (state != IDLE);
    assign set_ovf   = drop_full || rate_viol;
    assign rd_valid  = (level != '0);
    assign do_pop    = rd_valid && rd_ready;
    assign rd_data   = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst && do_push)
            mem[wr_ptr] <= link_data;
    end

    // Fullness is judged on the level at cycle start, so a same-cycle pop never frees room for a push.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)
                level <= level + (AW+1)'(1);
            else if (!do_push && do_pop)
                level <= level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            overflow <= 1'b0;
        else if (set_ovf)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end

`ifdef DEBUG_LINK_RX_OVFCNT_EN
    logic [7:0] cnt_q;
    logic [8:0] cnt_sum;

    assign cnt_sum = {1'b0, cnt_q} + {8'd0, drop_full} + {8'd0, rate_viol};

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (set_ovf)
            cnt_q <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        else if (ovf_clr)
            cnt_q <= '0;
    end

    assign ovf_cnt = cnt_q;
`else
    assign ovf_cnt = '0;
`endif
endmodule

// File: tb/tb_debug_link_rx.sv
// Self-checking bench for debug_link_rx: directed scenarios plus a randomized run against a queue model.
module tb_debug_link_rx;
    localparam int WIDTH = 13;
    localparam int DEPTH = 16;
    localparam int SETTLE = 2;
    localparam int SETTLE_B = 4;
    localparam int LAT = SETTLE + 4;
`ifdef DEBUG_LINK_RX_OVFCNT_EN
    localparam int OVF_EN = 1;
`else
    localparam int OVF_EN = 0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             link_clk = 1'b0;
    logic [WIDTH-1:0] link_data = '0;
    logic             rd_ready = 1'b0;
    logic             ovf_clr = 1'b0;

    logic [WIDTH-1:0] rd_data, rd_data_b;
    logic             rd_valid, rd_valid_b;
    logic [4:0]       level, level_b;
    logic             overflow, overflow_b;
    logic [7:0]       ovf_cnt, ovf_cnt_b;

    int n_tests = 0;
    int n_fail = 0;
    logic [WIDTH-1:0] model_q[$];
    int model_lost;
    logic model_ovf;

    debug_link_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .link_clk(link_clk), .link_data(link_data),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .level(level), .overflow(overflow), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt)
    );

    debug_link_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE(SETTLE_B)) dut_b (
        .clk(clk), .rst(rst), .link_clk(link_clk), .link_data(link_data),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .rd_ready(rd_ready),
        .level(level_b), .overflow(overflow_b), .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (4) tick();
        model_q.delete();
        model_lost = 0;
        model_ovf = 1'b0;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d);
        link_data = d;
        link_clk = ~link_clk;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_valid got %0b want 0", rd_valid); end
        n_tests++; if (rd_data !== '0) begin n_fail++; $display("[TB] FAIL reset_rd_data got %h want 0", rd_data); end
        n_tests++; if (level !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_level got %0d want 0", level); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overflow got %0b want 0", overflow); end
        n_tests++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_ovf_cnt got %0d want 0", ovf_cnt); end
    endtask

    task automatic test_latency();
        do_reset();
        send_word(13'h0A5);
        for (int i = 0; i <= LAT; i++) begin
            tick();
            n_tests++;
            if (rd_valid !== (i >= LAT)) begin
                n_fail++;
                $display("[TB] FAIL latency_edge%0d rd_valid got %0b want %0b", i, rd_valid, (i >= LAT));
            end
        end
        n_tests++; if (rd_data !== 13'h0A5) begin n_fail++; $display("[TB] FAIL latency_rd_data got %h want 0a5", rd_data); end
        n_tests++; if (level !== 5'd1) begin n_fail++; $display("[TB] FAIL latency_level got %0d want 1", level); end
    endtask

    task automatic test_zero_word();
        do_reset();
        send_word('0);
        repeat (12) tick();
        n_tests++; if (level !== 5'd0) begin n_fail++; $display("[TB] FAIL zero_level got %0d want 0", level); end
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_rd_valid got %0b want 0", rd_valid); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_overflow got %0b want 0", overflow); end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] d;
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            d = WIDTH'($urandom_range(1, (1 << WIDTH) - 1));
            if (model_q.size() < DEPTH) model_q.push_back(d);
            else begin model_lost++; model_ovf = 1'b1; end
            send_word(d);
            repeat (12) tick();
        end
        n_tests++; if (level !== 5'(model_q.size())) begin n_fail++; $display("[TB] FAIL full_level got %0d want %0d", level, model_q.size()); end
        n_tests++; if (overflow !== model_ovf) begin n_fail++; $display("[TB] FAIL full_overflow got %0b want %0b", overflow, model_ovf); end
        n_tests++; if (ovf_cnt !== 8'(model_lost * OVF_EN)) begin n_fail++; $display("[TB] FAIL full_ovf_cnt got %0d want %0d", ovf_cnt, model_lost * OVF_EN); end
        n_tests++; if (rd_data !== model_q[0]) begin n_fail++; $display("[TB] FAIL full_head got %h want %h", rd_data, model_q[0]); end
    endtask

    task automatic test_full_pop();
        // continues from the full FIFO left by test_overflow; pop lands in the SAMPLE cycle
        send_word(13'h1234);
        for (int i = 0; i < LAT; i++) tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        void'(model_q.pop_front());
        model_lost++;
        tick();
        n_tests++; if (level !== 5'(model_q.size())) begin n_fail++; $display("[TB] FAIL fullpop_level got %0d want %0d", level, model_q.size()); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("[TB] FAIL fullpop_overflow got %0b want 1", overflow); end
        n_tests++; if (ovf_cnt !== 8'(model_lost * OVF_EN)) begin n_fail++; $display("[TB] FAIL fullpop_ovf_cnt got %0d want %0d", ovf_cnt, model_lost * OVF_EN); end
        n_tests++; if (rd_data !== model_q[0]) begin n_fail++; $display("[TB] FAIL fullpop_head got %h want %h", rd_data, model_q[0]); end
    endtask

    task automatic test_ovf_clr();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_overflow got %0b want 0", overflow); end
        n_tests++; if (ovf_cnt !== 8'd0) begin n_fail++; $display("[TB] FAIL clr_ovf_cnt got %0d want 0", ovf_cnt); end
    endtask

    task automatic test_rate_violation();
        do_reset();
        send_word(13'h0777);
        repeat (2) tick();
        link_clk = ~link_clk;
        repeat (20) tick();
        n_tests++; if (level_b !== 5'd1) begin n_fail++; $display("[TB] FAIL rate_level_b got %0d want 1", level_b); end
        n_tests++; if (overflow_b !== 1'b1) begin n_fail++; $display("[TB] FAIL rate_overflow_b got %0b want 1", overflow_b); end
        n_tests++; if (ovf_cnt_b !== 8'(OVF_EN)) begin n_fail++; $display("[TB] FAIL rate_ovf_cnt_b got %0d want %0d", ovf_cnt_b, OVF_EN); end
        n_tests++; if (rd_data_b !== 13'h0777) begin n_fail++; $display("[TB] FAIL rate_head_b got %h want 0777", rd_data_b); end
        n_tests++; if (level !== 5'd1) begin n_fail++; $display("[TB] FAIL rate_level got %0d want 1", level); end
    endtask

    task automatic test_reset_cases();
        rst = 1'b1;
        link_clk = 1'b1;
        link_data = 13'h0055;
        do_reset();
        repeat (12) tick();
        n_tests++; if (level !== 5'd0) begin n_fail++; $display("[TB] FAIL rst_high_level got %0d want 0", level); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_high_overflow got %0b want 0", overflow); end
        send_word(13'h0066);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (15) tick();
        n_tests++; if (level !== 5'd0) begin n_fail++; $display("[TB] FAIL rst_wait_level got %0d want 0", level); end
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_wait_rd_valid got %0b want 0", rd_valid); end
    endtask

    task automatic test_random();
        int next_send, arrive;
        logic [WIDTH-1:0] pend;
        bit pop;
        int sz;
        do_reset();
        next_send = 2;
        arrive = -1;
        pend = '0;
        for (int c = 0; c < 900; c++) begin
            if (c == next_send) begin
                pend = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom_range(1, (1 << WIDTH) - 1));
                send_word(pend);
                arrive = c + LAT;
                next_send = c + 12 + $urandom_range(0, 5);
            end
            rd_ready = ($urandom_range(0, 15) == 0);
            tick();
            sz = model_q.size();
            pop = rd_ready && (sz > 0);
            if (pop) void'(model_q.pop_front());
            if (c == arrive && pend != '0) begin
                if (sz == DEPTH) begin model_lost++; model_ovf = 1'b1; end
                else model_q.push_back(pend);
            end
            n_tests++; if (level !== 5'(model_q.size())) begin n_fail++; $display("[TB] FAIL rand_level c=%0d got %0d want %0d", c, level, model_q.size()); end
            n_tests++; if (rd_valid !== (model_q.size() != 0)) begin n_fail++; $display("[TB] FAIL rand_rd_valid c=%0d got %0b want %0b", c, rd_valid, model_q.size() != 0); end
            if (model_q.size() != 0) begin
                n_tests++; if (rd_data !== model_q[0]) begin n_fail++; $display("[TB] FAIL rand_rd_data c=%0d got %h want %h", c, rd_data, model_q[0]); end
            end
            n_tests++; if (overflow !== model_ovf) begin n_fail++; $display("[TB] FAIL rand_overflow c=%0d got %0b want %0b", c, overflow, model_ovf); end
            n_tests++; if (ovf_cnt !== 8'((model_lost > 255 ? 255 : model_lost) * OVF_EN)) begin n_fail++; $display("[TB] FAIL rand_ovf_cnt c=%0d got %0d want %0d", c, ovf_cnt, model_lost * OVF_EN); end
        end
        rd_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_zero_word();
        test_overflow();
        test_full_pop();
        test_ovf_clr();
        test_rate_violation();
        test_reset_cases();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
